ball_game_ctrl: RTL and testbench
=================================

Name: ball_game_ctrl

Overview:
Game sequencer for the tilt-ball game. It drives the ball positioner's reset-position and pause inputs, and watches the ball position for target and hole hits. It also owns the lives/score/countdown bookkeeping. It sits between the button inputs, the ball positioner and the display overlay.

Parameters:
TICK_DIV, 1048576, clk cycles per game tick (internal free-running divider)
TARGET_X, 200, target centre x (px)
TARGET_Y, 100, target centre y (px)
TARGET_R, 16, target capture radius (px)
HOLE_X, 100, hole centre x (px)
HOLE_Y, 450, hole centre y (px)
HOLE_R, 16, hole capture radius (px)
LIVES, 3, lives per game (1..3)
COUNTDOWN, 3, countdown ticks before play (1..3)
HOLD_TICKS, 16, ticks spent in GOAL/FALL display states
ROUND_TICKS, 255, round time limit in ticks (only with macro)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
i_btn_start  in  1  start/abort button, raw level
i_btn_pause  in  1  pause toggle button, raw level
i_ball_x  in  9  ball centre x from positioner
i_ball_y  in  10  ball centre y from positioner
o_reset_position  out  1  to positioner i_reset_position
o_pause  out  1  to positioner i_pause
o_state  out  3  IDLE=0 COUNT=1 PLAY=2 PAUSED=3 GOAL=4 FALL=5 OVER=6
o_lives  out  2  remaining lives
o_score  out  8  goals scored, saturating
o_countdown  out  2  remaining countdown ticks
o_time_left  out  8  remaining round ticks (0 without macro)

Behaviour:
- Reset is arst_n, asynchronous, active-low; clock is clk.
- Reset values: state IDLE, o_reset_position=1, o_pause=1, o_lives=0, o_score=0, o_countdown=0, o_time_left=0. Tick divider=0; synchroniser and edge flops=0.
- Buttons: each passes through a 2-flop synchroniser, then a rising-edge detector. This gives a 1-cycle edge pulse 3 cycles after the raw rise. Holding a button produces no further edges.
- Tick: the divider counts 0..TICK_DIV-1 while arst_n is high. A 1-cycle tick pulse fires at TICK_DIV-1, and the divider wraps to 0. The divider runs in every state.
- Hit test (1-cycle pipeline):
  - dx = ball_x - CX and dy = ball_y - CY, as signed 11-bit values.
  - dx², dy² and their sum are computed unsigned at 23 bits.
  - hit = sum <= R². The result is registered.
  - Hits are ignored during the first 2 cycles of PLAY, to flush stale positions.
- Outputs by state:
  - o_reset_position=1 in IDLE and COUNT, 0 otherwise.
  - o_pause=0 only in PLAY, 1 otherwise.
- Transitions:
  - IDLE: start edge -> COUNT; lives=LIVES, score=0, countdown=COUNTDOWN.
  - COUNT: each tick decrements countdown. A tick arriving while countdown==1 -> PLAY with countdown=0.
  - PLAY:
    - hole hit -> FALL; lives decrement on entry.
    - else target hit -> GOAL; score +1 on entry, saturating at 255.
    - else pause edge -> PAUSED.
    - Hole wins over target; either hit wins over pause in the same cycle.
  - PAUSED: pause edge -> PLAY; the 2-cycle hit mask re-applies. Start edge -> IDLE. Start wins if both arrive together.
  - GOAL: after HOLD_TICKS ticks -> COUNT; countdown reloads.
  - FALL: after HOLD_TICKS ticks -> OVER if lives==0, else COUNT with countdown reloaded.
  - OVER: start edge -> IDLE. Lives and score hold for display.
- Start edges in COUNT, PLAY, GOAL and FALL are ignored. Pause edges outside PLAY and PAUSED are ignored.
- The hold counter is 5-bit and clears on each entry to GOAL or FALL.
- arst_n assertion in any state returns all outputs to their reset values asynchronously.

Optional Feature:
ROUND_TIMEOUT_EN
- Defined:
  - Entering PLAY from COUNT loads o_time_left=ROUND_TICKS.
  - Each tick in PLAY decrements o_time_left. PAUSED freezes it.
  - A tick arriving while o_time_left==1 is treated as a hole hit -> FALL, with the same life decrement.
  - A real hit in the same cycle takes priority: a target hit goes to GOAL.
- Undefined: o_time_left is tied to 0; there is no time limit.

Test Plan:
Setup for all scenarios: TICK_DIV=4, HOLD_TICKS=2, COUNTDOWN=3, ball held at (200,300).
- Start edge in IDLE -> COUNT; countdown steps 3,2,1 on ticks, then PLAY. o_reset_position stays 1 through COUNT and falls on PLAY entry. o_pause=0 in PLAY.
- In PLAY, drive ball to (205,110): dist²=125<=256 -> GOAL one cycle after the hit register. Score 0->1. COUNT after 2 ticks.
- Ball at (100,450) with LIVES=1 -> FALL, lives 1->0, then OVER after 2 ticks. Start edge -> IDLE.
- Pause edge in PLAY -> PAUSED with o_pause=1. Simultaneous pause+start edges -> IDLE.
- Ball placed on the target during the first PLAY cycle is ignored. If still there at cycle 3 -> GOAL. Score saturates at 255 after the 256th goal.
- arst_n pulsed low mid-FALL -> state IDLE, lives 0, o_pause=1, o_reset_position=1 immediately.
- With ROUND_TIMEOUT_EN and ROUND_TICKS=5 -> FALL after 5 PLAY ticks. A pause during PLAY freezes o_time_left.

Source files
------------

// File: rtl/ball_game_ctrl.sv
// ball_game_ctrl - tilt-ball game sequencer.
// Synchronises the start/pause buttons, derives a slow game tick, runs the
// hit test against the target and the hole, and sequences the game through
// IDLE/COUNT/PLAY/PAUSED/GOAL/FALL/OVER while keeping lives, score and countdown.
// Optional feature: define ROUND_TIMEOUT_EN to add a per-round time limit
// (o_time_left); without it o_time_left is tied to 0.
module ball_game_ctrl #(
    parameter int TICK_DIV    = 1048576,
    parameter int TARGET_X    = 200,
    parameter int TARGET_Y    = 100,
    parameter int TARGET_R    = 16,
    parameter int HOLE_X      = 100,
    parameter int HOLE_Y      = 450,
    parameter int HOLE_R      = 16,
    parameter int LIVES       = 3,
    parameter int COUNTDOWN   = 3,
    parameter int HOLD_TICKS  = 16,
    parameter int ROUND_TICKS = 255
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_btn_start,
    input  logic       i_btn_pause,
    input  logic [8:0] i_ball_x,
    input  logic [9:0] i_ball_y,
    output logic       o_reset_position,
    output logic       o_pause,
    output logic [2:0] o_state,
    output logic [1:0] o_lives,
    output logic [7:0] o_score,
    output logic [1:0] o_countdown,
    output logic [7:0] o_time_left
);

`ifdef ROUND_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COUNT  = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_GOAL   = 3'd4,
        S_FALL   = 3'd5,
        S_OVER   = 3'd6
    } state_t;

    // Squared-distance capture test; magnitudes are taken first so the
    // squares stay unsigned at 23 bits.
    function automatic logic in_radius(input logic [8:0] x, input logic [9:0] y,
                                       input int cx, input int cy, input int r);
        logic [10:0] dx, dy, adx, ady;
        logic [22:0] sum;
        dx  = {2'b00, x} - 11'(cx);
        dy  = {1'b0, y} - 11'(cy);
        adx = dx[10] ? (~dx + 11'd1) : dx;
        ady = dy[10] ? (~dy + 11'd1) : dy;
        sum = 23'(adx) * 23'(adx) + 23'(ady) * 23'(ady);
        return sum <= 23'(r * r);
    endfunction

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       start_pipe_q, start_pipe_d;   // [0] meta, [1] sync, [2] previous
    logic [2:0]       pause_pipe_q, pause_pipe_d;
    logic             tgt_hit_q, tgt_hit_d;
    logic             hole_hit_q, hole_hit_d;
    logic [1:0]       mask_q, mask_d;               // PLAY cycles still ignoring hits
    logic [4:0]       hold_q, hold_d;
    logic [1:0]       lives_q, lives_d;
    logic [7:0]       score_q, score_d;
    logic [1:0]       cd_q, cd_d;
    logic [7:0]       time_q, time_d;

    logic tick, start_edge, pause_edge, hit_ok, timeout;

    // Front end: tick divider, button synchronisers/edge detect, hit pipeline.
    always_comb begin
        tick         = (div_q == DIV_W'(TICK_DIV - 1));
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        start_pipe_d = {start_pipe_q[1:0], i_btn_start};
        pause_pipe_d = {pause_pipe_q[1:0], i_btn_pause};
        start_edge   = start_pipe_q[1] & ~start_pipe_q[2];
        pause_edge   = pause_pipe_q[1] & ~pause_pipe_q[2];
        tgt_hit_d    = in_radius(i_ball_x, i_ball_y, TARGET_X, TARGET_Y, TARGET_R);
        hole_hit_d   = in_radius(i_ball_x, i_ball_y, HOLE_X, HOLE_Y, HOLE_R);
    end

    // Next-state and bookkeeping for the game sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        mask_d  = mask_q;
        hold_d  = hold_q;
        lives_d = lives_q;
        score_d = score_q;
        cd_d    = cd_q;
        time_d  = time_q;
        hit_ok  = (mask_q == 2'd0);
        timeout = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_COUNT;
                    lives_d = 2'(LIVES);
                    score_d = 8'd0;
                    cd_d    = 2'(COUNTDOWN);
                end
            end
            S_COUNT: begin
                if (tick) begin
                    if (cd_q == 2'd1) begin
                        state_d = S_PLAY;
                        cd_d    = 2'd0;
                        mask_d  = 2'd2;
                        if (TIMEOUT_EN) time_d = 8'(ROUND_TICKS);
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end
            end
            S_PLAY: begin
                if (mask_q != 2'd0) mask_d = mask_q - 2'd1;
                if (TIMEOUT_EN && tick && time_q != 8'd0) begin
                    time_d  = time_q - 8'd1;
                    timeout = (time_q == 8'd1);
                end
                // Hole beats target; a real hit beats the timeout; any fall beats pause.
                if ((hit_ok && hole_hit_q) || (timeout && !(hit_ok && tgt_hit_q))) begin
                    state_d = S_FALL;
                    hold_d  = 5'd0;
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end else if (hit_ok && tgt_hit_q) begin
                    state_d = S_GOAL;
                    hold_d  = 5'd0;
                    if (score_q != 8'hff) score_d = score_q + 8'd1;
                end else if (pause_edge) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (start_edge) begin
                    state_d = S_IDLE;
                end else if (pause_edge) begin
                    state_d = S_PLAY;
                    mask_d  = 2'd2;
                end
            end
            S_GOAL, S_FALL: begin
                if (tick) begin
                    if (hold_q == 5'(HOLD_TICKS - 1)) begin
                        if (state_q == S_FALL && lives_q == 2'd0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_COUNT;
                            cd_d    = 2'(COUNTDOWN);
                        end
                    end else begin
                        hold_d = hold_q + 5'd1;
                    end
                end
            end
            S_OVER: begin
                if (start_edge) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All state flops, cleared asynchronously by arst_n.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            start_pipe_q <= 3'd0;
            pause_pipe_q <= 3'd0;
            tgt_hit_q    <= 1'b0;
            hole_hit_q   <= 1'b0;
            mask_q       <= 2'd0;
            hold_q       <= 5'd0;
            lives_q      <= 2'd0;
            score_q      <= 8'd0;
            cd_q         <= 2'd0;
            time_q       <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            div_q        <= div_d;
            start_pipe_q <= start_pipe_d;
            pause_pipe_q <= pause_pipe_d;
            tgt_hit_q    <= tgt_hit_d;
            hole_hit_q   <= hole_hit_d;
            mask_q       <= mask_d;
            hold_q       <= hold_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            cd_q         <= cd_d;
            time_q       <= time_d;
        end
    end

    assign o_state          = state_q;
    assign o_reset_position = (state_q == S_IDLE) || (state_q == S_COUNT);
    assign o_pause          = (state_q != S_PLAY);
    assign o_lives          = lives_q;
    assign o_score          = score_q;
    assign o_countdown      = cd_q;
    assign o_time_left      = time_q;

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Testbench for ball_game_ctrl: directed game walk-throughs plus randomized
// buttons/ball motion, compared every cycle against a behavioural game model.
module tb_ball_game_ctrl;

    localparam int TICK_DIV = 4;
    localparam int HOLD     = 2;
    localparam int CD       = 3;
    localparam int LIVES    = 2;
    localparam int ROUND    = 5;
    localparam int TX = 200, TY = 100, TR = 16;
    localparam int HX = 100, HY = 450, HR = 16;

`ifdef ROUND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int IDLE = 0, COUNT = 1, PLAY = 2, PAUSED = 3, GOAL = 4, FALL = 5, OVER = 6;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic       i_btn_start = 1'b0;
    logic       i_btn_pause = 1'b0;
    logic [8:0] i_ball_x = 9'd200;
    logic [9:0] i_ball_y = 10'd300;
    logic       o_reset_position, o_pause;
    logic [2:0] o_state;
    logic [1:0] o_lives, o_countdown;
    logic [7:0] o_score, o_time_left;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    ball_game_ctrl #(
        .TICK_DIV(TICK_DIV), .TARGET_X(TX), .TARGET_Y(TY), .TARGET_R(TR),
        .HOLE_X(HX), .HOLE_Y(HY), .HOLE_R(HR), .LIVES(LIVES),
        .COUNTDOWN(CD), .HOLD_TICKS(HOLD), .ROUND_TICKS(ROUND)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .i_btn_start(i_btn_start), .i_btn_pause(i_btn_pause),
        .i_ball_x(i_ball_x), .i_ball_y(i_ball_y),
        .o_reset_position(o_reset_position), .o_pause(o_pause),
        .o_state(o_state), .o_lives(o_lives), .o_score(o_score),
        .o_countdown(o_countdown), .o_time_left(o_time_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_state = IDLE, m_lives = 0, m_score = 0, m_cd = 0, m_tl = 0;
    int m_hold = 0, m_entry = 0, cyc = 0;
    bit m_hole_prev = 0, m_tgt_prev = 0;
    bit st_hist[$];   // raw start samples of the last three edges, oldest first
    bit pa_hist[$];

    function automatic bit near(input int x, input int y, input int cx, input int cy, input int r);
        return (x - cx) * (x - cx) + (y - cy) * (y - cy) <= r * r;
    endfunction

    always @(posedge clk or negedge arst_n) begin : model
        bit tick, se, pe, ok, to;
        if (!arst_n) begin
            m_state = IDLE; m_lives = 0; m_score = 0; m_cd = 0; m_tl = 0;
            m_hold = 0; m_entry = 0; cyc = 0;
            m_hole_prev = 0; m_tgt_prev = 0;
            st_hist = '{1'b0, 1'b0, 1'b0};
            pa_hist = '{1'b0, 1'b0, 1'b0};
        end else begin
            cyc++;
            tick = (cyc % TICK_DIV) == 0;
            // An edge acts two edges after the raw level was first sampled high.
            se = st_hist[1] && !st_hist[0];
            pe = pa_hist[1] && !pa_hist[0];
            case (m_state)
                IDLE: if (se) begin
                    m_state = COUNT; m_lives = LIVES; m_score = 0; m_cd = CD;
                end
                COUNT: if (tick) begin
                    if (m_cd == 1) begin
                        m_cd = 0; m_state = PLAY; m_entry = cyc;
                        if (TO_EN) m_tl = ROUND;
                    end else m_cd--;
                end
                PLAY: begin
                    ok = (cyc - m_entry) >= 3;
                    to = TO_EN && tick && (m_tl == 1);
                    if (tick && m_tl > 0) m_tl--;
                    if (ok && m_hole_prev) begin
                        m_state = FALL; m_lives--; m_hold = 0;
                    end else if (ok && m_tgt_prev) begin
                        m_state = GOAL; m_hold = 0;
                        if (m_score < 255) m_score++;
                    end else if (to) begin
                        m_state = FALL; m_lives--; m_hold = 0;
                    end else if (pe) m_state = PAUSED;
                end
                PAUSED: begin
                    if (se) m_state = IDLE;
                    else if (pe) begin m_state = PLAY; m_entry = cyc; end
                end
                GOAL, FALL: if (tick) begin
                    m_hold++;
                    if (m_hold == HOLD) begin
                        if (m_state == FALL && m_lives == 0) m_state = OVER;
                        else begin m_state = COUNT; m_cd = CD; end
                    end
                end
                OVER: if (se) m_state = IDLE;
                default: ;
            endcase
            st_hist.push_back(i_btn_start); void'(st_hist.pop_front());
            pa_hist.push_back(i_btn_pause); void'(pa_hist.pop_front());
            m_tgt_prev  = near(int'(i_ball_x), int'(i_ball_y), TX, TY, TR);
            m_hole_prev = near(int'(i_ball_x), int'(i_ball_y), HX, HY, HR);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (arst_n && cmp_on) begin
            check("cmp_state", int'(o_state), m_state);
            check("cmp_reset_position", int'(o_reset_position), (m_state == IDLE || m_state == COUNT) ? 1 : 0);
            check("cmp_pause", int'(o_pause), (m_state == PLAY) ? 0 : 1);
            check("cmp_lives", int'(o_lives), m_lives);
            check("cmp_score", int'(o_score), m_score);
            check("cmp_countdown", int'(o_countdown), m_cd);
            check("cmp_time_left", int'(o_time_left), m_tl);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input bit s, input bit p);
        @(negedge clk);
        i_btn_start = s; i_btn_pause = p;
        repeat (4) @(negedge clk);
        i_btn_start = 1'b0; i_btn_pause = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, input string what);
        int n = 0;
        while (int'(o_state) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(what, int'(o_state), s);
    endtask

    task automatic ball(input int x, input int y);
        i_ball_x = 9'(x);
        i_ball_y = 10'(y);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        check("rst_state", int'(o_state), IDLE);
        check("rst_lives", int'(o_lives), 0);
        check("rst_pause", int'(o_pause), 1);
        check("rst_reset_position", int'(o_reset_position), 1);
        #1 arst_n = 1'b1;
    endtask

    initial begin
        int prev_cd, n, goals, prev_s;

        #2 arst_n = 1'b0;
        #10;
        check("reset_state", int'(o_state), IDLE);
        check("reset_reset_position", int'(o_reset_position), 1);
        check("reset_pause", int'(o_pause), 1);
        check("reset_score", int'(o_score), 0);
        check("reset_time_left", int'(o_time_left), 0);
        #11 arst_n = 1'b1;
        cmp_on = 1'b1;

        // Start -> COUNT with countdown 3,2,1 -> PLAY.
        @(negedge clk);
        i_btn_start = 1'b1;
        wait_state(COUNT, 10, "start_to_count");
        check("count_cd_load", int'(o_countdown), 3);
        check("count_lives", int'(o_lives), LIVES);
        check("count_reset_position", int'(o_reset_position), 1);
        i_btn_start = 1'b0;
        prev_cd = 3;
        n = 0;
        while (int'(o_state) == COUNT && n < 40) begin
            @(negedge clk);
            n++;
            if (int'(o_state) == COUNT && int'(o_countdown) != prev_cd) begin
                check("count_step", int'(o_countdown), prev_cd - 1);
                prev_cd = int'(o_countdown);
            end
        end
        check("count_to_play", int'(o_state), PLAY);
        check("play_cd_zero", int'(o_countdown), 0);
        check("play_reset_position", int'(o_reset_position), 0);
        check("play_pause", int'(o_pause), 0);

        // Goal: (205,110) is 125 px^2 from the target centre.
        ball(205, 110);
        wait_state(GOAL, 10, "goal_reached");
        check("goal_score", int'(o_score), 1);
        ball(200, 300);
        wait_state(COUNT, 20, "goal_to_count");
        wait_state(PLAY, 30, "count_to_play2");

        // Pause, then pause+start together -> IDLE.
        press(1'b0, 1'b1);
        wait_state(PAUSED, 10, "pause_entry");
        check("paused_pause", int'(o_pause), 1);
        press(1'b1, 1'b1);
        wait_state(IDLE, 10, "pause_start_idle");

        // Two falls -> OVER, then start -> IDLE.
        press(1'b1, 1'b0);
        wait_state(PLAY, 30, "play_for_fall1");
        ball(HX, HY);
        wait_state(FALL, 10, "fall1");
        check("fall1_lives", int'(o_lives), 1);
        ball(200, 300);
        wait_state(PLAY, 40, "play_for_fall2");
        ball(HX, HY);
        wait_state(FALL, 10, "fall2");
        check("fall2_lives", int'(o_lives), 0);
        wait_state(OVER, 20, "fall_to_over");
        ball(200, 300);
        press(1'b1, 1'b0);
        wait_state(IDLE, 10, "over_to_idle");

        // Asynchronous reset in the middle of FALL.
        press(1'b1, 1'b0);
        wait_state(PLAY, 30, "play_for_rst");
        ball(HX, HY);
        wait_state(FALL, 10, "fall_for_rst");
        ball(200, 300);
        pulse_reset();

        // Hit mask: target placed in the first PLAY cycle is ignored for 2 cycles.
        press(1'b1, 1'b0);
        wait_state(PLAY, 30, "play_for_mask");
        ball(TX, TY);
        @(negedge clk);
        check("mask_cycle1", int'(o_state), PLAY);
        @(negedge clk);
        check("mask_cycle2", int'(o_state), PLAY);
        @(negedge clk);
        check("mask_goal", int'(o_state), GOAL);
        check("mask_goal_score", int'(o_score), 1);

        // Score saturation: keep the ball on the target for 256 more goals.
        goals = 0;
        n = 0;
        prev_s = int'(o_state);
        while (goals < 256 && n < 12000) begin
            @(negedge clk);
            n++;
            if (int'(o_state) == GOAL && prev_s != GOAL) goals++;
            prev_s = int'(o_state);
        end
        check("sat_goals", goals, 256);
        check("sat_score", int'(o_score), 255);
        ball(200, 300);

        // Randomized play checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) i_btn_start = ~i_btn_start;
            if ($urandom_range(0, 11) == 0) i_btn_pause = ~i_btn_pause;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: ball(200, 300);
                    4, 5:       ball(TX - 20 + int'($urandom_range(0, 40)), TY - 20 + int'($urandom_range(0, 40)));
                    6, 7:       ball(HX - 20 + int'($urandom_range(0, 40)), HY - 20 + int'($urandom_range(0, 40)));
                    default:    ball(int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)));
                endcase
            end
            if (i == 2000) pulse_reset();
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
